// File: rtl/burst_main_mem_pkg.sv
// Shared definitions for the burst main memory.
//   state_e       : burst FSM states
//   ACC_*         : acc_size encodings for 1/4/8/16-beat bursts
//   MEM_BASE_ADDR : default byte address mapped to storage index 0
//   burst_len()   : beat count for an acc_size code
package burst_main_mem_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    localparam logic [31:0] MEM_BASE_ADDR = 32'h8002_0000;

    function automatic logic [4:0] burst_len(input logic [1:0] acc);
        logic [4:0] len;
        unique case (acc)
            ACC_1W:  len = 5'd1;
            ACC_4W:  len = 5'd4;
            ACC_8W:  len = 5'd8;
            default: len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage array with a word-wide big-endian port.
//   clk_i    : rising-edge clock
//   rst_ni   : synchronous active-low reset (clears the read register only)
//   we_i     : write one word at addr_i, lanes gated by be_i
//   re_i     : read one word at addr_i into rdata_o (one-cycle latency)
//   addr_i   : byte index of the word, aligned to the word size
//   be_i     : lane enables, MSB lane = lowest address
//   wdata_i  : write data, MSB byte at the lowest address
//   rdata_o  : registered read data; holds when re_i=0
// Storage contents are never reset.
module mem_byte_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1048576
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o
);

    localparam int unsigned B    = DATA_W / 8;
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int j = 0; j < B; j++) begin
                if (be_i[B-1-j]) begin
                    mem_q[addr_i + IdxW'(j)] <= wdata_i[DATA_W-1-8*j -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            for (int j = 0; j < B; j++) begin
                rdata_q[DATA_W-1-8*j -: 8] <= mem_q[addr_i + IdxW'(j)];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_main_mem.sv
// Byte-addressed, big-endian unified main memory with a registered burst engine.
// A request moves 1/4/8/16 beats; out-of-range or misaligned requests pulse err_o.
//   clk_i       : rising-edge clock
//   rst_ni      : synchronous active-low reset
//   en_i        : request strobe, sampled only while busy_o=0
//   wren_i      : 1=write burst, 0=read burst (latched at accept)
//   acc_size_i  : 00=1 beat, 01=4, 10=8, 11=16 (latched at accept)
//   addr_i      : burst start byte address (latched at accept)
//   d_in_i      : write beat data, MSB byte at the lowest address
//   d_out_o     : registered read beat data
//   d_valid_o   : d_out_o carries a new read beat this cycle
//   busy_o      : burst in progress, requests ignored
//   err_o       : one-cycle pulse, request rejected
//   byte_en_i   : write lane enables, MSB lane first (only with MEM_BYTE_LANES_EN)
// Build option: define MEM_BYTE_LANES_EN to add byte_en_i; otherwise all lanes are written.
module burst_main_mem
    import burst_main_mem_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        MEM_BYTES = 1048576,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(MEM_BASE_ADDR),
    parameter int unsigned        MAX_BURST = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  wren_i,
    input  logic [1:0]            acc_size_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     d_in_i,
    output logic [DATA_W-1:0]     d_out_o,
    output logic                  d_valid_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef MEM_BYTE_LANES_EN
    ,
    input  logic [DATA_W/8-1:0]   byte_en_i
`endif
);

    localparam int unsigned B       = DATA_W / 8;
    localparam int unsigned LB      = $clog2(B);
    localparam int unsigned IdxW    = $clog2(MEM_BYTES);
    localparam int unsigned CntW    = $clog2(MAX_BURST);
    localparam int unsigned AW1     = ADDR_W + 1;
    localparam bit          Allow16 = (MAX_BURST >= 16);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     base_q, base_d;
    logic                wren_q, wren_d;
    logic                d_valid_q;
    logic                err_q;

    // Request decode and validity check, evaluated once at accept.
    logic [AW1-1:0]      off;
    logic [AW1-1:0]      span_end;
    logic [4:0]          req_len;
    logic                req_ok;
    logic                accept;
    logic                accept_ok;
    logic                reject;

    logic                mem_we;
    logic                mem_re;
    logic [IdxW-1:0]     mem_addr;
    logic [B-1:0]        mem_be;

    always_comb begin
        // The extra top bit of off is the borrow: set when addr_i < BASE_ADDR.
        off      = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        req_len  = burst_len(acc_size_i);
        span_end = off + AW1'(req_len) * AW1'(B);
        req_ok   = !off[ADDR_W]
                && ((addr_i & ADDR_W'(B - 1)) == '0)
                && (span_end <= AW1'(MEM_BYTES))
                && (Allow16 || (acc_size_i != ACC_16W));
        accept    = (state_q == StIdle) && en_i;
        accept_ok = accept && req_ok;
        reject    = accept && !req_ok;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= '0;
            base_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wren_q  <= wren_d;
        end
    end

    // Next-state logic. Beat 0 is served on the accept edge itself, so the
    // counter enters BURST already pointing at beat 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        base_d  = base_q;
        wren_d  = wren_q;
        unique case (state_q)
            StIdle: begin
                if (accept_ok) begin
                    base_d = off[IdxW-1:0];
                    wren_d = wren_i;
                    last_d = CntW'(req_len - 5'd1);
                    if (req_len != 5'd1) begin
                        cnt_d   = CntW'(1);
                        state_d = StBurst;
                    end
                end
            end
            StBurst: begin
                if (cnt_q == last_q) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and storage control. Memory ops are gated by rst_ni so a reset
    // edge never commits a beat.
    always_comb begin
        busy_o   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = off[IdxW-1:0];
        unique case (state_q)
            StIdle: begin
                mem_we = rst_ni && accept_ok && wren_i;
                mem_re = rst_ni && accept_ok && !wren_i;
            end
            StBurst: begin
                busy_o   = 1'b1;
                mem_addr = base_q + (IdxW'(cnt_q) << LB);
                mem_we   = rst_ni && wren_q;
                mem_re   = rst_ni && !wren_q;
            end
            default: ;
        endcase
    end

`ifdef MEM_BYTE_LANES_EN
    assign mem_be = byte_en_i;
`else
    assign mem_be = '1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            d_valid_q <= mem_re;
            err_q     <= reject;
        end
    end

    assign d_valid_o = d_valid_q;
    assign err_o     = err_q;

    mem_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_BYTES)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .be_i    (mem_be),
        .wdata_i (d_in_i),
        .rdata_o (d_out_o)
    );

endmodule

// File: tb/tb_burst_main_mem.sv
module tb_burst_main_mem;
    import burst_main_mem_pkg::*;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int unsigned BYTES = 1048576;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wren;
    logic [1:0]  acc;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        d_valid;
    logic        busy;
    logic        err;
`ifdef MEM_BYTE_LANES_EN
    logic [3:0]  be_g;
`endif

    always #5 clk = ~clk;

    burst_main_mem dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .wren_i     (wren),
        .acc_size_i (acc),
        .addr_i     (addr),
        .d_in_i     (d_in),
        .d_out_o    (d_out),
        .d_valid_o  (d_valid),
        .busy_o     (busy),
        .err_o      (err)
`ifdef MEM_BYTE_LANES_EN
        ,
        .byte_en_i  (be_g)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: sparse byte store of every byte the bench has written.
    logic [7:0]  mdl [int unsigned];
    logic [31:0] wdat [16];
    logic [31:0] last_rd;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic int nbeats(logic [1:0] a);
        return (a == 2'd0) ? 1 : (4 << (a - 2'd1));
    endfunction

    function automatic void mdl_write(int unsigned idx, logic [31:0] w, logic [3:0] lanes);
        for (int j = 0; j < 4; j++)
            if (lanes[3-j]) mdl[idx + j] = w[31-8*j -: 8];
    endfunction

    function automatic bit mdl_read(int unsigned idx, output logic [31:0] w);
        bit known = 1'b1;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            if (mdl.exists(idx + j)) w[31-8*j -: 8] = mdl[idx + j];
            else known = 1'b0;
        end
        return known;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 16; k++) wdat[k] = $urandom;
    endtask

    // One accepted burst. abort_at>=0 pulls reset for two cycles at that beat edge.
    task automatic burst(input logic wr, input logic [1:0] a, input logic [31:0] ad,
                         input bit noisy, input int abort_at);
        int          n;
        int unsigned idx;
        logic [31:0] exp_w;
        logic [3:0]  lanes;
        n     = nbeats(a);
        idx   = ad - BASE;
        lanes = 4'hF;
`ifdef MEM_BYTE_LANES_EN
        lanes = be_g;
`endif
        en = 1'b1; wren = wr; acc = a; addr = ad; d_in = wdat[0];
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                en    = 1'b0;
                for (int r = 0; r < 2; r++) begin
                    @(posedge clk); #1;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_dvalid", 32'(d_valid), 32'd0);
                    chk("abort_err", 32'(err), 32'd0);
                    chk("abort_dout", d_out, 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (wr) begin
                mdl_write(idx + 4 * k, wdat[k], lanes);
                chk("wr_dvalid", 32'(d_valid), 32'd0);
            end else begin
                chk("rd_dvalid", 32'(d_valid), 32'd1);
                if (mdl_read(idx + 4 * k, exp_w)) chk("rd_data", d_out, exp_w);
                last_rd = d_out;
            end
            chk("beat_busy", 32'(busy), 32'(k < n - 1));
            chk("beat_err", 32'(err), 32'd0);
            if (k < n - 1) begin
                d_in = wdat[k + 1];
                en   = noisy ? 1'($urandom) : 1'b0;
                if (noisy) begin
                    addr = $urandom;
                    wren = 1'($urandom);
                    acc  = 2'($urandom);
                end
            end else begin
                en = 1'b0;
            end
        end
    endtask

    task automatic rejected(input logic wr, input logic [1:0] a, input logic [31:0] ad);
        en = 1'b1; wren = wr; acc = a; addr = ad; d_in = $urandom;
        @(posedge clk); #1;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_dvalid", 32'(d_valid), 32'd0);
        en = 1'b0;
        @(posedge clk); #1;
        chk("rej_err_pulse", 32'(err), 32'd0);
        chk("rej_busy2", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] ad;
        logic        exp_err;
    } req_t;

    req_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, ACC_1W,  32'h8002_0002, 1'b1};
        tbl[1]  = '{1'b0, ACC_1W,  32'h8001_FFFC, 1'b1};
        tbl[2]  = '{1'b0, ACC_16W, 32'h8011_FFE0, 1'b1};
        tbl[3]  = '{1'b0, ACC_8W,  32'h8011_FFE0, 1'b0};
        tbl[4]  = '{1'b1, ACC_1W,  32'h8002_0001, 1'b1};
        tbl[5]  = '{1'b0, ACC_4W,  32'h8011_FFF4, 1'b1};
        tbl[6]  = '{1'b1, ACC_4W,  32'h8011_FFF0, 1'b0};
        tbl[7]  = '{1'b0, ACC_4W,  32'h8011_FFF0, 1'b0};
        tbl[8]  = '{1'b0, ACC_1W,  32'h8012_0000, 1'b1};
        tbl[9]  = '{1'b0, ACC_1W,  32'h8011_FFFC, 1'b0};
        tbl[10] = '{1'b1, ACC_1W,  32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, ACC_16W, 32'hFFFF_FFF0, 1'b1};

        rst_n = 1'b0; en = 1'b0; wren = 1'b0; acc = 2'b00; addr = '0; d_in = '0;
        last_rd = '0;
`ifdef MEM_BYTE_LANES_EN
        be_g = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dvalid", 32'(d_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dout", d_out, 32'd0);
        rst_n = 1'b1;

        // Known contents for the first 512 bytes, back-to-back 16-beat writes.
        for (int i = 0; i < 8; i++) begin
            fill_random();
            burst(1'b1, ACC_16W, BASE + 32'(64 * i), 1'b0, -1);
        end

        // Single write then single read.
        wdat[0] = 32'hDEAD_BEEF;
        burst(1'b1, ACC_1W, BASE, 1'b0, -1);
        burst(1'b0, ACC_1W, BASE, 1'b0, -1);
        chk("single_rd", last_rd, 32'hDEAD_BEEF);

        // 8-beat write then 8-beat read, back to back.
        for (int k = 0; k < 8; k++) wdat[k] = 32'(k + 1) * 32'h1111_1111;
        burst(1'b1, ACC_8W, 32'h8002_0010, 1'b0, -1);
        burst(1'b0, ACC_8W, 32'h8002_0010, 1'b0, -1);
        chk("burst8_last", last_rd, 32'h8888_8888);

        // Noisy request inputs during a 16-beat read.
        burst(1'b0, ACC_16W, BASE, 1'b1, -1);

        // Validity table.
        for (int i = 0; i < 12; i++) begin
            fill_random();
            if (tbl[i].exp_err) rejected(tbl[i].wr, tbl[i].a, tbl[i].ad);
            else burst(tbl[i].wr, tbl[i].a, tbl[i].ad, 1'b0, -1);
        end
        burst(1'b0, ACC_16W, BASE, 1'b0, -1);

        // Reset mid read burst, then mid write burst; committed beats persist.
        burst(1'b0, ACC_16W, BASE, 1'b0, 5);
        fill_random();
        burst(1'b1, ACC_8W, 32'h8002_0040, 1'b0, 3);
        burst(1'b0, ACC_8W, 32'h8002_0040, 1'b0, -1);

`ifdef MEM_BYTE_LANES_EN
        wdat[0] = 32'h0;
        burst(1'b1, ACC_1W, 32'h8002_0100, 1'b0, -1);
        be_g = 4'b0101;
        wdat[0] = 32'hAABB_CCDD;
        burst(1'b1, ACC_1W, 32'h8002_0100, 1'b0, -1);
        be_g = 4'hF;
        burst(1'b0, ACC_1W, 32'h8002_0100, 1'b0, -1);
        chk("lanes", last_rd, 32'h00BB_00DD);
`endif

        // Random traffic inside the known window.
        for (int i = 0; i < 40; i++) begin
            logic        r_wr;
            logic [1:0]  r_a;
            int          n;
            r_wr = 1'($urandom);
            r_a  = 2'($urandom);
            n    = nbeats(r_a);
`ifdef MEM_BYTE_LANES_EN
            be_g = 4'($urandom);
`endif
            fill_random();
            burst(r_wr, r_a, BASE + 32'(4 * $urandom_range(0, (512 - 4 * n) / 4)),
                  1'($urandom), -1);
        end

        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
